// File: rtl/pc_ctrl_sequencer.sv
// Fetch/execute control sequencer for the 16-bit PC register stage.
// Drives the PC control bundle {reset, inc, write_en}, load data and instruction-memory reads.
module pc_ctrl_sequencer #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       instr,
    input  logic             zflag,
    output logic             mem_rd,
    output logic [2:0]       ctrlsig,
    output logic [3:0]       pc_datain,
    output logic             ir_load,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    // state | meaning
    // IDLE  | waiting for start after reset, all outputs low
    // RSTPC | one-cycle PC reset pulse
    // FETCH | one-cycle instruction-memory read request
    // WAIT  | memory latency; last cycle captures instr and zflag
    // EXEC  | one control action on the PC for the captured instruction
    // HALT  | parked until start, halted high
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RSTPC = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_EXEC  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JZ   = 4'h2;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] CTRL_NONE  = 3'b000;
    localparam logic [2:0] CTRL_RESET = 3'b100;
    localparam logic [2:0] CTRL_INC   = 3'b010;
    localparam logic [2:0] CTRL_WRITE = 3'b001;

    localparam logic [3:0]       LAT_LAST = 4'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       ir_q, ir_d;
    logic             z_q, z_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    logic             capture;

    assign capture = (state_q == S_WAIT) && (lat_cnt_q == LAT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ir_q          <= 8'h00;
            z_q           <= 1'b0;
            lat_cnt_q     <= 4'd0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            z_q           <= z_d;
            lat_cnt_q     <= lat_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        z_d           = z_q;
        lat_cnt_d     = lat_cnt_q;
        instr_count_d = instr_count_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d       = S_RSTPC;
                    instr_count_d = '0;
                end
            end
            S_RSTPC: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                lat_cnt_d = 4'd0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (capture) begin
                    ir_d    = instr;
                    z_d     = zflag;
                    state_d = S_EXEC;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            S_EXEC: begin
                // Saturating count: HALT retires too, so it is counted here as well.
                if (!(&instr_count_q)) begin
                    instr_count_d = instr_count_q + CNT_ONE;
                end
                if (ir_q[7:4] == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state, so inputs never reach outputs combinationally.
    always_comb begin
        mem_rd    = 1'b0;
        ctrlsig   = CTRL_NONE;
        pc_datain = 4'h0;
        ir_load   = 1'b0;
        halted    = 1'b0;

        case (state_q)
            S_RSTPC: ctrlsig = CTRL_RESET;
            S_FETCH: mem_rd  = 1'b1;
            S_WAIT:  ir_load = capture;
            S_EXEC: begin
                case (ir_q[7:4])
                    OP_JMP: begin
                        ctrlsig   = CTRL_WRITE;
                        pc_datain = ir_q[3:0];
                    end
                    OP_JZ: begin
                        if (z_q) begin
                            ctrlsig   = CTRL_WRITE;
                            pc_datain = ir_q[3:0];
                        end else begin
                            ctrlsig = CTRL_INC;
                        end
                    end
                    OP_HALT: ctrlsig = CTRL_NONE;
                    default: ctrlsig = CTRL_INC;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign instr_count = instr_count_q;

endmodule

// File: doc/pc_ctrl_sequencer.md
Name: pc_ctrl_sequencer

Overview:
- Upstream control stage for the 16-bit program-counter register stage.
- Runs a fetch/execute state machine that drives the PC stage's 3-bit control bundle {reset, inc, write_en} and its 4-bit load data, and reads instruction bytes from instruction memory.
- Decodes a minimal jump/halt instruction subset, so the PC stage sees exactly one control action per instruction.
- Clocked by the same clock as the PC stage.

Parameters:
- MEM_LAT, 2, instruction-memory read latency in cycles from mem_rd to valid instr; legal range 1..15.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled high in IDLE or HALT starts or restarts the program.
- instr  input  8  instruction-memory read data; [7:4] opcode, [3:0] operand.
- zflag  input  1  zero flag from datapath; sampled on the ir_load edge.
- mem_rd  output  1  one-cycle instruction-memory read request.
- ctrlsig  output  3  PC control bundle: [2]=reset, [1]=inc, [0]=write_en.
- pc_datain  output  4  PC load value; meaningful only when ctrlsig[0]=1.
- ir_load  output  1  pulse on the cycle instr is captured.
- halted  output  1  high while in HALT.
- instr_count  output  CNT_W  retired-instruction count, saturating.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; ir=8'h00; z_q=0; latency counter=0; instr_count=0.
  - All outputs 0.
  - Reset is honoured mid-instruction; no pending action completes.
- All outputs are decoded from the state register, ir and z_q only. There is no combinational path from any input to any output.
- Exactly one ctrlsig bit is high at a time, or none.
- States:
  - IDLE: outputs 0. start=1 -> RSTPC.
  - RSTPC: ctrlsig=3'b100 for 1 cycle -> FETCH.
  - FETCH: mem_rd=1 for 1 cycle; counter<=0 -> WAIT.
  - WAIT: if counter==MEM_LAT-1, then ir<=instr, z_q<=zflag, ir_load=1 this cycle, -> EXEC; else counter++.
  - EXEC: decode ir[7:4] as below, then -> FETCH, except HALT.
    - 4'h1 JMP: ctrlsig=3'b001, pc_datain=ir[3:0].
    - 4'h2 JZ: if z_q, ctrlsig=3'b001 and pc_datain=ir[3:0]; else ctrlsig=3'b010.
    - 4'hF HALT: ctrlsig=3'b000 -> HALT.
    - All other opcodes (NOP/ALU): ctrlsig=3'b010.
  - HALT: halted=1; ctrlsig=0. start=1 -> RSTPC (restart from PC reset); otherwise stay.
- Instruction period is MEM_LAT+2 cycles (FETCH + MEM_LAT WAIT cycles + EXEC).
- pc_datain = 4'h0 in every cycle other than EXEC of a taken JMP/JZ.
- instr_count:
  - Increments by 1 in every EXEC cycle, HALT included.
  - Saturates at all-ones with no wrap.
  - Cleared on restart (entry to RSTPC) as well as on reset.
- start is ignored in RSTPC, FETCH, WAIT and EXEC.
- instr is don't-care except on the capture cycle.

Test Plan:
- Reset mid-WAIT, then release -> all outputs 0 immediately on reset_n falling edge (asynchronous), state IDLE; after release, nothing moves until start.
- MEM_LAT=2. start=1 at edge 0, memory returns 8'h00 -> ctrlsig=100 in cycle 1; mem_rd in cycle 2; ir_load in cycle 4; ctrlsig=010 in cycle 5; next mem_rd in cycle 6; instr_count=1 after cycle 5.
- instr=8'h1A (JMP 0xA) -> in EXEC, ctrlsig=001 and pc_datain=4'hA for exactly one cycle, then FETCH.
- JZ 8'h25:
  - zflag=1 at capture -> ctrlsig=001, pc_datain=5.
  - zflag=0 at capture, zflag toggled to 1 during EXEC -> ctrlsig=010 (sampled value used).
- instr=8'hF0 -> halted=1, ctrlsig=000 held for 20+ cycles, no mem_rd. start pulse -> RSTPC ctrlsig=100, instr_count=0, halted=0.
- CNT_W=2, run 5 NOPs -> instr_count reads 1, 2, 3, 3, 3 (saturates). MEM_LAT=1 -> period 3 cycles, ir_load in the cycle immediately after mem_rd.
